activation_skew_feeder: RTL and testbench
=========================================

Name: activation_skew_feeder

Overview:
- Parametrised systolic-array input feeder.
- Accepts a full N x N activation matrix over a valid/ready handshake and streams it as diagonally skewed, zero-padded lanes: lane r is delayed r cycles, one lane per array row.
- Double-buffered: a second matrix can be queued during streaming, so consecutive matrices stream with no gap.
- Supports a global stall that freezes the array.

Parameters:
- N, 2, array dimension; matrix is N x N, N lanes out; N >= 2.
- DW, 8, element width in bits.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_data holds a valid matrix.
- in_ready  output  1  feeder can accept a matrix this cycle.
- in_data  input  N*N*DW  row-major matrix; A[r][k] at bits [(r*N+k)*DW +: DW].
- stall  input  1  freeze streaming state and outputs.
- a_out  output  N*DW  lane r at bits [r*DW +: DW]; registered.
- out_valid  output  1  a_out is a schedule step of a matrix.
- out_last  output  1  a_out is the final step (2N-2) of a matrix.
- busy  output  1  state is STREAM or a matrix is pending.

Behaviour:
- Reset (async): state IDLE; step=0; pend_full=0; active/pending buffers=0; a_out=0; out_valid=0; out_last=0.
- in_ready = !pend_full (combinational from register; 1 during and after reset).
- Handshake: a transfer occurs on a rising edge with in_valid & in_ready. in_data is sampled only on transfer. Transfers are independent of stall.
- Schedule: step t in 0..2N-2. Lane r outputs A[r][t-r] if 0 <= t-r <= N-1, else 0. A matrix therefore takes 2N-1 output cycles.
- Step counter: width max(1, $clog2(2N-1)); never exceeds 2N-2.
- IDLE:
  - Transfer -> load active, step=0, go to STREAM.
  - Outputs: a_out=0, out_valid=0, out_last=0.
- STREAM, stall=0, each edge:
  - a_out <= skew(active, step); out_valid <= 1; out_last <= (step==2N-2).
  - If step < 2N-2: step++.
  - If step == 2N-2 and pend_full: active <= pending, pend_full <= 0, step=0, stay in STREAM (gapless).
  - If step == 2N-2, !pend_full, and a transfer this edge: active <= in_data directly (bypass), step=0, stay in STREAM.
  - Otherwise at step == 2N-2: go to IDLE.
  - A transfer at any other STREAM edge writes pending; pend_full <= 1.
- STREAM, stall=1: a_out, out_valid, out_last, step and active all hold. A transfer may still fill pending.
- Stall in IDLE: no effect, except that a transfer still moves to STREAM. The first output then waits for stall=0.
- Latency: transfer on edge E (IDLE) -> step 0 on a_out after edge E+1; out_last after edge E+2N-1 (no stall).
- Matrix boundaries:
  - Lane r is nonzero only at steps r..r+N-1.
  - Back-to-back matrices are adjacent with no zero bubble.
  - No overlap/merging of skew tails between matrices.
- busy = (state==STREAM) | pend_full.
- Reset mid-stream: immediate abort, with the reset values above. A pending matrix is discarded.
- All arithmetic is index selection only; no data modification or sign handling.

Test Plan:
- Single matrix, N=2, DW=8:
  - Stimulus: A=[[1,2],[3,4]] transferred at edge 0.
  - Response: (lane0,lane1) = (1,0),(2,3),(0,4) after edges 1..3; out_last only with (0,4); out_valid=0 and a_out=0 from edge 4.
- Back-to-back, N=2:
  - Stimulus: A as above at edge 0; B=[[5,6],[7,8]] at edge 1 (goes to pending).
  - Response: outputs (1,0),(2,3),(0,4),(5,0),(6,7),(0,8), contiguous; out_last twice; in_ready=0 from edge 1 until edge 3.
- Bypass at last step:
  - Stimulus: B transferred exactly on edge 3 with pending empty.
  - Response: (5,0) appears after edge 4, no gap.
- Stall, N=2:
  - Stimulus: stall=1 for 3 cycles after edge 2.
  - Response: a_out held at (2,3) with out_valid held at 1; stream resumes with (0,4); total cycles = 3 + 3.
- Reset mid-stream:
  - Stimulus: assert reset asynchronously after edge 2 with a pending matrix.
  - Response: all outputs 0 immediately; in_ready=1; busy=0; next transfer restarts at step 0.
- N=4, DW=16:
  - Stimulus: A[r][k] = 16*r + k + 1.
  - Response: step 3 shows lanes (4,19,34,49); 7 output steps; lane 3 zero at steps 0-2.

Source files
------------

// File: rtl/activation_skew_feeder.sv
// rtl/activation_skew_feeder.sv - double-buffered, diagonally skewed matrix feeder for a systolic array
//
// Takes one N x N activation matrix per valid/ready handshake and plays it out
// over 2N-1 cycles. Lane r carries row r of the matrix delayed by r cycles, and
// lanes are zero outside their window. A second matrix can wait in a pending
// buffer, so consecutive matrices stream with no gap. While stall is high the
// streaming state and outputs are frozen.
//
// Ports:
//   clk       - clock, rising edge
//   reset     - asynchronous active-high reset
//   in_valid  - in_data holds a matrix (row-major, A[r][k] at (r*N+k)*DW)
//   in_ready  - feeder can accept a matrix this cycle
//   in_data   - N*N*DW matrix
//   stall     - freeze streaming state and outputs
//   a_out     - lane r at [r*DW +: DW], registered
//   out_valid - a_out is a schedule step of a matrix
//   out_last  - a_out is the final step (2N-2) of a matrix
//   busy      - streaming, or a matrix is pending
module activation_skew_feeder #(
    parameter int N  = 2,
    parameter int DW = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N*N*DW-1:0] in_data,
    input  logic              stall,
    output logic [N*DW-1:0]   a_out,
    output logic              out_valid,
    output logic              out_last,
    output logic              busy
);

    localparam int SW = ($clog2(2*N-1) > 1) ? $clog2(2*N-1) : 1;
    localparam logic [SW-1:0] LAST_STEP = SW'(2*N-2);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t              state_q, state_d;
    logic [SW-1:0]       step_q, step_d;
    logic                pend_full_q, pend_full_d;
    logic [N*N*DW-1:0]   active_q, active_d;
    logic [N*N*DW-1:0]   pending_q, pending_d;
    logic [N*DW-1:0]     a_out_q, a_out_d;
    logic                out_valid_q, out_valid_d;
    logic                out_last_q, out_last_d;
    logic [N*DW-1:0]     skew_data;
    logic                xfer;

    assign in_ready  = !pend_full_q;
    assign xfer      = in_valid && !pend_full_q;
    assign a_out     = a_out_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign busy      = (state_q == STREAM) || pend_full_q;

    // Element A[r][k] belongs on lane r at step r+k; everything else is zero.
    always_comb begin
        skew_data = '0;
        for (int r = 0; r < N; r++) begin
            for (int k = 0; k < N; k++) begin
                if (int'(step_q) == r + k) begin
                    skew_data[r*DW +: DW] = active_q[(r*N+k)*DW +: DW];
                end
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        pend_full_d = pend_full_q;
        active_d    = active_q;
        pending_d   = pending_q;
        a_out_d     = a_out_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;

        case (state_q)
            IDLE: begin
                a_out_d     = '0;
                out_valid_d = 1'b0;
                out_last_d  = 1'b0;
                if (xfer) begin
                    active_d = in_data;
                    step_d   = '0;
                    state_d  = STREAM;
                end
            end
            STREAM: begin
                if (stall) begin
                    // Outputs and schedule hold; the input side keeps working.
                    if (xfer) begin
                        pending_d   = in_data;
                        pend_full_d = 1'b1;
                    end
                end else begin
                    a_out_d     = skew_data;
                    out_valid_d = 1'b1;
                    out_last_d  = (step_q == LAST_STEP);
                    if (step_q != LAST_STEP) begin
                        step_d = step_q + SW'(1);
                        if (xfer) begin
                            pending_d   = in_data;
                            pend_full_d = 1'b1;
                        end
                    end else if (pend_full_q) begin
                        active_d    = pending_q;
                        pend_full_d = 1'b0;
                        step_d      = '0;
                    end else if (xfer) begin
                        // Nothing pending: the new matrix goes straight to active.
                        active_d = in_data;
                        step_d   = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            step_q      <= '0;
            pend_full_q <= 1'b0;
            active_q    <= '0;
            pending_q   <= '0;
            a_out_q     <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            pend_full_q <= pend_full_d;
            active_q    <= active_d;
            pending_q   <= pending_d;
            a_out_q     <= a_out_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
        end
    end

endmodule

// File: tb/tb_activation_skew_feeder.sv
// tb/tb_activation_skew_feeder.sv - self-checking bench for activation_skew_feeder
module tb_activation_skew_feeder;

    logic        clk = 1'b0;
    logic        reset;

    logic        v2, s2, rdy2, ov2, ol2, busy2;
    logic [31:0] d2;
    logic [15:0] a2;

    logic        v4, s4, rdy4, ov4, ol4, busy4;
    logic [255:0] d4;
    logic [63:0] a4;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    activation_skew_feeder #(.N(2), .DW(8)) dut2 (
        .clk(clk), .reset(reset), .in_valid(v2), .in_ready(rdy2), .in_data(d2),
        .stall(s2), .a_out(a2), .out_valid(ov2), .out_last(ol2), .busy(busy2)
    );

    activation_skew_feeder #(.N(4), .DW(16)) dut4 (
        .clk(clk), .reset(reset), .in_valid(v4), .in_ready(rdy4), .in_data(d4),
        .stall(s4), .a_out(a4), .out_valid(ov4), .out_last(ol4), .busy(busy4)
    );

    // Expected lane vector at schedule step t: lane r shows A[r][t-r] when in range.
    function automatic logic [63:0] exp_skew(input logic [255:0] m, input int n, input int dw, input int t);
        logic [63:0] res;
        int k;
        res = '0;
        for (int r = 0; r < n; r++) begin
            k = t - r;
            if (k >= 0 && k < n)
                for (int b = 0; b < dw; b++) res[r*dw+b] = m[(r*n+k)*dw+b];
        end
        return res;
    endfunction

    function automatic logic [31:0] mat2(input int a00, input int a01, input int a10, input int a11);
        return {a11[7:0], a10[7:0], a01[7:0], a00[7:0]};
    endfunction

    task automatic tick2(input logic v, input logic s, input logic [31:0] d);
        v2 = v; s2 = s; d2 = d;
        @(posedge clk); #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        #3;
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        v2 = 0; s2 = 0; d2 = '0; v4 = 0; s4 = 0; d4 = '0;
        #2;
        n_cmp++;
        if ({a2, ov2, ol2, busy2, rdy2} !== {16'h0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_state: got a=%h v=%b l=%b busy=%b rdy=%b, want a=0 v=0 l=0 busy=0 rdy=1", a2, ov2, ol2, busy2, rdy2);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if ({a2, ov2, rdy2, busy2} !== {16'h0, 1'b0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_idle: got a=%h v=%b rdy=%b busy=%b, want 0/0/1/0", a2, ov2, rdy2, busy2);
        end
    endtask

    task automatic test_single;
        logic [15:0] exp_a [4] = '{16'h0001, 16'h0302, 16'h0400, 16'h0000};
        logic exp_v [4] = '{1, 1, 1, 0};
        logic exp_l [4] = '{0, 0, 1, 0};
        tick2(1, 0, mat2(1, 2, 3, 4));
        n_cmp++;
        if ({ov2, busy2, rdy2} !== 3'b011) begin
            n_fail++;
            $display("FAIL single_after_xfer: got v=%b busy=%b rdy=%b, want 0/1/1", ov2, busy2, rdy2);
        end
        for (int i = 0; i < 4; i++) begin
            tick2(0, 0, '0);
            n_cmp++;
            if ({a2, ov2, ol2} !== {exp_a[i], exp_v[i], exp_l[i]}) begin
                n_fail++;
                $display("FAIL single_step%0d: got a=%h v=%b l=%b, want a=%h v=%b l=%b", i, a2, ov2, ol2, exp_a[i], exp_v[i], exp_l[i]);
            end
        end
        n_cmp++;
        if (busy2 !== 1'b0) begin
            n_fail++;
            $display("FAIL single_busy_end: got %b want 0", busy2);
        end
    endtask

    task automatic test_back_to_back;
        logic [15:0] exp_a [6] = '{16'h0001, 16'h0302, 16'h0400, 16'h0005, 16'h0706, 16'h0800};
        logic exp_l [6] = '{0, 0, 1, 0, 0, 1};
        logic exp_r [6] = '{0, 0, 1, 1, 1, 1};
        tick2(1, 0, mat2(1, 2, 3, 4));
        v2 = 1; s2 = 0; d2 = mat2(5, 6, 7, 8);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            v2 = 0;
            n_cmp++;
            if ({a2, ov2, ol2, rdy2} !== {exp_a[i], 1'b1, exp_l[i], exp_r[i]}) begin
                n_fail++;
                $display("FAIL b2b_step%0d: got a=%h v=%b l=%b rdy=%b, want a=%h v=1 l=%b rdy=%b", i, a2, ov2, ol2, rdy2, exp_a[i], exp_l[i], exp_r[i]);
            end
        end
        tick2(0, 0, '0);
        n_cmp++;
        if ({ov2, busy2} !== 2'b00) begin
            n_fail++;
            $display("FAIL b2b_end: got v=%b busy=%b, want 0/0", ov2, busy2);
        end
    endtask

    task automatic test_bypass;
        tick2(1, 0, mat2(1, 2, 3, 4));
        tick2(0, 0, '0);
        tick2(0, 0, '0);
        tick2(1, 0, mat2(5, 6, 7, 8));
        n_cmp++;
        if ({a2, ol2, rdy2} !== {16'h0400, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL bypass_last: got a=%h l=%b rdy=%b, want a=0400 l=1 rdy=1", a2, ol2, rdy2);
        end
        tick2(0, 0, '0);
        n_cmp++;
        if ({a2, ov2, ol2} !== {16'h0005, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL bypass_first: got a=%h v=%b l=%b, want a=0005 v=1 l=0", a2, ov2, ol2);
        end
        tick2(0, 0, '0);
        tick2(0, 0, '0);
        tick2(0, 0, '0);
        n_cmp++;
        if ({ov2, busy2} !== 2'b00) begin
            n_fail++;
            $display("FAIL bypass_end: got v=%b busy=%b, want 0/0", ov2, busy2);
        end
    endtask

    task automatic test_stall;
        tick2(1, 0, mat2(1, 2, 3, 4));
        tick2(0, 0, '0);
        tick2(0, 0, '0);
        for (int i = 0; i < 3; i++) begin
            tick2(0, 1, '0);
            n_cmp++;
            if ({a2, ov2, ol2} !== {16'h0302, 1'b1, 1'b0}) begin
                n_fail++;
                $display("FAIL stall_hold%0d: got a=%h v=%b l=%b, want a=0302 v=1 l=0", i, a2, ov2, ol2);
            end
        end
        tick2(0, 0, '0);
        n_cmp++;
        if ({a2, ov2, ol2} !== {16'h0400, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL stall_resume: got a=%h v=%b l=%b, want a=0400 v=1 l=1", a2, ov2, ol2);
        end
        tick2(0, 0, '0);
        n_cmp++;
        if ({ov2, busy2} !== 2'b00) begin
            n_fail++;
            $display("FAIL stall_end: got v=%b busy=%b, want 0/0", ov2, busy2);
        end
    endtask

    task automatic test_reset_mid;
        tick2(1, 0, mat2(1, 2, 3, 4));
        tick2(1, 0, mat2(5, 6, 7, 8));
        v2 = 0;
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({a2, ov2, ol2, rdy2, busy2} !== {16'h0, 1'b0, 1'b0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_mid: got a=%h v=%b l=%b rdy=%b busy=%b, want 0/0/0/1/0", a2, ov2, ol2, rdy2, busy2);
        end
        #1;
        reset = 1'b0;
        @(posedge clk); #1;
        tick2(1, 0, mat2(9, 10, 11, 12));
        tick2(0, 0, '0);
        n_cmp++;
        if ({a2, ov2, ol2} !== {16'h0009, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_restart: got a=%h v=%b l=%b, want a=0009 v=1 l=0", a2, ov2, ol2);
        end
        for (int i = 0; i < 3; i++) tick2(0, 0, '0);
    endtask

    task automatic test_n4;
        logic [255:0] m;
        logic [63:0] e;
        for (int r = 0; r < 4; r++)
            for (int k = 0; k < 4; k++) m[(r*4+k)*16 +: 16] = 16'(16*r + k + 1);
        v4 = 1; d4 = m; s4 = 0;
        @(posedge clk); #1;
        v4 = 0;
        for (int t = 0; t < 8; t++) begin
            @(posedge clk); #1;
            e = (t < 7) ? exp_skew(m, 4, 16, t) : 64'h0;
            n_cmp++;
            if ({a4, ov4, ol4} !== {e, (t < 7), (t == 6)}) begin
                n_fail++;
                $display("FAIL n4_step%0d: got a=%h v=%b l=%b, want a=%h v=%b l=%b", t, a4, ov4, ol4, e, (t < 7), (t == 6));
            end
            if (t == 3) begin
                n_cmp++;
                if (a4 !== {16'd49, 16'd34, 16'd19, 16'd4}) begin
                    n_fail++;
                    $display("FAIL n4_step3_lanes: got %h want 0031002200130004", a4);
                end
            end
            if (t < 3) begin
                n_cmp++;
                if (a4[63:48] !== 16'h0) begin
                    n_fail++;
                    $display("FAIL n4_lane3_zero%0d: got %h want 0", t, a4[63:48]);
                end
            end
        end
    endtask

    // Random traffic against a queue model: the queue holds the streaming matrix
    // followed by at most one waiting matrix; pos is the schedule step of the head.
    task automatic test_random;
        logic [31:0] mq[$];
        int pos = 0;
        logic [15:0] e_a = '0;
        logic e_v = 0, e_l = 0;
        logic v, s, xf;
        logic [31:0] d;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            v = 1'($urandom_range(0, 1));
            s = ($urandom_range(0, 3) == 0);
            d = $urandom;
            xf = v && (mq.size() < 2);
            tick2(v, s, d);
            if (mq.size() > 0) begin
                if (!s) begin
                    e_a = exp_skew({224'h0, mq[0]}, 2, 8, pos)[15:0];
                    e_v = 1;
                    e_l = (pos == 2);
                    pos++;
                    if (pos == 3) begin
                        void'(mq.pop_front());
                        pos = 0;
                    end
                end
            end else begin
                e_a = '0; e_v = 0; e_l = 0;
            end
            if (xf) mq.push_back(d);
            n_cmp++;
            if ({a2, ov2, ol2, rdy2, busy2} !== {e_a, e_v, e_l, (mq.size() < 2), (mq.size() > 0)}) begin
                n_fail++;
                $display("FAIL random_cycle%0d: got a=%h v=%b l=%b rdy=%b busy=%b, want a=%h v=%b l=%b rdy=%b busy=%b",
                         i, a2, ov2, ol2, rdy2, busy2, e_a, e_v, e_l, (mq.size() < 2), (mq.size() > 0));
            end
        end
        v2 = 0; s2 = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_bypass();
        test_stall();
        test_reset_mid();
        test_n4();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
